irq_controller: RTL and testbench
=================================

# irq_controller

Interrupt controller for the 8-bit microcontroller core, sitting beside the program sequencer. It synchronises and edge-detects external interrupt lines, arbitrates by fixed priority under a mask and global enable, and forces the sequencer to jump to a per-line vector. It saves the return address on a small stack and issues a full 8-bit return jump when the program executes a return-from-interrupt.

## Interface
- NUM_IRQ, 4, number of interrupt lines (1..4); line 0 has the highest priority.
- VEC_BASE, 4'hC, jump_address nibble for line 0; line n vectors to VEC_BASE+n, giving addresses {VEC_BASE+n, 4'h0}.
- STACK_DEPTH, 4, return-address stack depth; used only with nesting.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- irq  in  NUM_IRQ  external interrupt requests, asynchronous; a rising edge requests service.
- mask_we  in  1  write strobe for the mask register.
- mask_data  in  NUM_IRQ  new mask value; 1 = line enabled.
- ei  in  1  enable-interrupts instruction strobe; sets gie.
- di  in  1  disable-interrupts instruction strobe; clears gie.
- reti  in  1  return-from-interrupt instruction strobe.
- hold  in  1  1 while the current instruction is a jump or conditional jump; defers entry.
- pc  in  8  current sequencer pc.
- irq_jump  out  1  one-cycle pulse that forces the sequencer to jump.
- irq_jump_address  out  4  vector nibble; valid while irq_jump=1, otherwise 0.
- ret_jump  out  1  one-cycle pulse that forces the sequencer to load ret_addr.
- ret_addr  out  8  popped return address; valid while ret_jump=1, otherwise 0.
- irq_pending  out  NUM_IRQ  pending latches.
- irq_active  out  NUM_IRQ  in-service bits.
- irq_depth  out  3  number of stack entries in use.

## Operation
- Each irq bit passes through a 2-flop synchroniser, then a third flop for edge detection. A 0→1 transition sets that line's pending bit.
- A line is eligible when: pending=1, mask=1, gie=1, hold=0, state=IDLE, and the line is not blocked by the in-service rule (see Configuration).
- Only the lowest-index eligible line is taken.
- State machine:
  - IDLE → ENTER when any line is eligible.
  - ENTER lasts one cycle. During it: irq_jump=1; irq_jump_address=VEC_BASE+n; push (pc+1) mod 256, so 8'hFF wraps to 8'h00; clear pending[n]; set active[n]. Next state is IDLE.
  - IDLE → RETURN on reti=1 with irq_depth>0.
  - RETURN lasts one cycle. During it: ret_jump=1; ret_addr = top of stack; pop; clear the most recently set active bit. Next state is IDLE.
  - reti with irq_depth=0 is ignored.
- Simultaneous events:
  - reti and an eligible line in the same cycle: RETURN wins; the line may enter on the cycle after RETURN.
  - An edge that sets pending[n] in the same cycle ENTER clears it: set wins.
  - mask_we during an arbitration cycle: the decision uses the old mask; the new mask takes effect the next cycle.
  - ei and di in the same cycle: di wins.
- Entering an interrupt does not change gie.
- Reset values:
  - State IDLE.
  - mask, gie, pending, active, irq_depth, stack contents and synchroniser flops all 0.
  - irq_jump, irq_jump_address, ret_jump and ret_addr all 0.
- Reset asserted mid-ENTER or mid-RETURN aborts the transfer. Outputs drop to 0 asynchronously.

## Timing
- irq rises before edge k: pending is visible after edge k+2.
- irq_jump is high in the cycle after pending becomes visible, provided the line is eligible, giving 3–4 cycles total latency.
- irq_jump and ret_jump are registered outputs, exactly one cycle wide, and never high together.
- At most one ENTER or RETURN occurs every two cycles, because of the IDLE gap between transfers.
- A pending bit stays set indefinitely while the line is masked or blocked.

## Configuration
- IRQ_NESTING_EN defined:
  - A higher-priority line (lower index than every active bit) may preempt a running handler.
  - The stack holds STACK_DEPTH entries.
  - Entry is blocked while irq_depth=STACK_DEPTH; the pending bit is retained.
- IRQ_NESTING_EN undefined:
  - Entry is blocked whenever any active bit is set.
  - The stack is a single register; irq_depth is only ever 0 or 1.
  - STACK_DEPTH is ignored.

## Test plan
- Single interrupt: reset, mask_data=4'b1111, ei, pulse irq[2], pc=8'h37 → irq_jump with irq_jump_address=4'hE; active=4'b0100. Then reti → ret_jump with ret_addr=8'h38; active=0.
- Priority: pending[1] and pending[3] set together, gie=1 → line 1 entered first (address 4'hD). After reti, line 3 is entered (address 4'hF).
- Gating: mask=4'b1110 with irq[0] edge → no jump and pending[0] stays 1. Write mask=4'b1111 → entry. Likewise hold=1 defers entry until hold=0, and di blocks entry.
- Wrap and simultaneous events: pc=8'hFF on entry → ret_addr=8'h00. reti and a new eligible request in the same cycle → RETURN first, then ENTER two cycles later.
- With IRQ_NESTING_EN: line 3 in service, irq[0] edge → preemption with irq_depth=2. Four nested lines fill the stack, so a fifth request stays pending. Returns pop the addresses in LIFO order.
- Reset mid-ENTER → outputs 0 immediately; pending, active and irq_depth all cleared.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: synchronises and edge-detects interrupt lines, arbitrates by
// fixed priority (line 0 highest) under mask and global enable, forces the
// sequencer to a per-line vector and returns through a saved-address stack.
// Optional feature macro: IRQ_NESTING_EN (preemption by higher-priority lines
// and a STACK_DEPTH-entry return stack; otherwise one handler at a time).
//
// Sequencer handshake: irq_jump and ret_jump are single-cycle registered
// pulses, never high together; irq_jump_address / ret_addr carry data only
// while their pulse is high and read 0 otherwise. There is no back-pressure:
// the sequencer must act on the pulse in the cycle it is seen.
module irq_controller #(
  parameter int         NUM_IRQ     = 4,
  parameter logic [3:0] VEC_BASE    = 4'hC,
  parameter int         STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               hold,
  input  logic [7:0]         pc,
  output logic               irq_jump,
  output logic [3:0]         irq_jump_address,
  output logic               ret_jump,
  output logic [7:0]         ret_addr,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_active,
  output logic [2:0]         irq_depth
);

`ifdef IRQ_NESTING_EN
  localparam int SD = STACK_DEPTH;
`else
  // Without nesting only one return address is ever held.
  localparam int SD = (STACK_DEPTH > 0) ? 1 : 1;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ENTER, ST_RETURN} state_t;

  state_t               state_q, state_d;
  logic [NUM_IRQ-1:0]   sync1_q, sync2_q, sync3_q, edge_w;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic                 gie_q, gie_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   active_q, active_d;
  logic [2:0]           depth_q, depth_d;
  logic [7:0]           stack_q [SD];
  logic [7:0]           stack_d [SD];
  logic [NUM_IRQ-1:0]   sel_q, sel_d;
  logic                 jump_q, jump_d;
  logic [3:0]           jaddr_q, jaddr_d;
  logic                 rjump_q, rjump_d;
  logic [7:0]           raddr_q, raddr_d;
  logic [NUM_IRQ-1:0]   grant;
  logic                 found;
  logic                 blocked;
  logic [3:0]           vec;
  logic [7:0]           top_w;
`ifdef IRQ_NESTING_EN
  logic [NUM_IRQ-1:0]   below;
  logic                 full;
`endif

  assign edge_w = sync2_q & ~sync3_q;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Arbitration, transfer FSM next state, stack push/pop and output pulses.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_we ? mask_data : mask_q;
    gie_d     = di ? 1'b0 : (ei ? 1'b1 : gie_q);
    pending_d = pending_q | edge_w;
    active_d  = active_q;
    depth_d   = depth_q;
    stack_d   = stack_q;
    sel_d     = sel_q;
    jump_d    = 1'b0;
    jaddr_d   = 4'h0;
    rjump_d   = 1'b0;
    raddr_d   = 8'h00;
    grant     = '0;
    found     = 1'b0;
    blocked   = 1'b0;
    vec       = 4'h0;
    top_w     = 8'h00;
`ifdef IRQ_NESTING_EN
    below     = '0;
    full      = (depth_q == 3'(SD));
`endif

    for (int j = 0; j < SD; j++) begin
      if (depth_q == 3'(j + 1)) top_w = stack_q[j];
    end

    // Lowest-index line that is pending, unmasked and not blocked wins.
    for (int i = 0; i < NUM_IRQ; i++) begin
`ifdef IRQ_NESTING_EN
      below[i] = 1'b1;
      blocked  = full || ((active_q & below) != '0);
`else
      blocked  = |active_q;
`endif
      if (!found && pending_q[i] && mask_q[i] && !blocked) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        vec      = VEC_BASE + 4'(i);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (reti && depth_q != 3'd0) begin
          state_d = ST_RETURN;
          rjump_d = 1'b1;
          raddr_d = top_w;
        end else if (found && gie_q && !hold) begin
          state_d = ST_ENTER;
          sel_d   = grant;
          jump_d  = 1'b1;
          jaddr_d = vec;
        end
      end
      ST_ENTER: begin
        state_d   = ST_IDLE;
        pending_d = (pending_q & ~sel_q) | edge_w;
        active_d  = active_q | sel_q;
        depth_d   = depth_q + 3'd1;
        for (int j = 0; j < SD; j++) begin
          if (depth_q == 3'(j)) stack_d[j] = pc + 8'd1;
        end
      end
      ST_RETURN: begin
        state_d  = ST_IDLE;
        // Most recent handler is always the lowest-index active line.
        active_d = active_q & (active_q - 1'b1);
        depth_d  = depth_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      gie_q     <= 1'b0;
      pending_q <= '0;
      active_q  <= '0;
      depth_q   <= 3'd0;
      for (int j = 0; j < SD; j++) stack_q[j] <= 8'h00;
      sel_q     <= '0;
      jump_q    <= 1'b0;
      jaddr_q   <= 4'h0;
      rjump_q   <= 1'b0;
      raddr_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      gie_q     <= gie_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      depth_q   <= depth_d;
      stack_q   <= stack_d;
      sel_q     <= sel_d;
      jump_q    <= jump_d;
      jaddr_q   <= jaddr_d;
      rjump_q   <= rjump_d;
      raddr_q   <= raddr_d;
    end
  end

  assign irq_jump         = jump_q;
  assign irq_jump_address = jaddr_q;
  assign ret_jump         = rjump_q;
  assign ret_addr         = raddr_q;
  assign irq_pending      = pending_q;
  assign irq_active       = active_q;
  assign irq_depth        = depth_q;

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed scenarios plus randomized traffic,
// every cycle checked against a queue-based behavioural model.
module tb_irq_controller;

`ifdef IRQ_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  localparam int MAX_DEPTH = 4;

  logic       clk, reset;
  logic [3:0] irq, mask_data;
  logic       mask_we, ei, di, reti, hold;
  logic [7:0] pc;
  logic       irq_jump, ret_jump;
  logic [3:0] irq_jump_address, irq_pending, irq_active;
  logic [7:0] ret_addr;
  logic [2:0] irq_depth;

  int n_checks = 0;
  int n_errors = 0;

  irq_controller dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_data(mask_data),
    .ei(ei), .di(di), .reti(reti), .hold(hold), .pc(pc),
    .irq_jump(irq_jump), .irq_jump_address(irq_jump_address),
    .ret_jump(ret_jump), .ret_addr(ret_addr),
    .irq_pending(irq_pending), .irq_active(irq_active), .irq_depth(irq_depth)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [3:0] m_s1, m_s2, m_s3, m_pend, m_mask, m_addr;
  bit         m_gie, m_jump, m_ret;
  logic [7:0] m_raddr;
  int         m_phase, m_line;          // phase: 0 idle, 1 entering, 2 returning
  int         act_q[$];                 // lines in service, last = most recent
  logic [7:0] exp_q[$];                 // saved return addresses, last = top

  function automatic logic [3:0] act_vec();
    logic [3:0] v;
    v = 4'h0;
    foreach (act_q[k]) v[act_q[k]] = 1'b1;
    return v;
  endfunction

  function automatic bit may_enter(int line);
    if (!NEST) return act_q.size() == 0;
    if (exp_q.size() >= MAX_DEPTH) return 1'b0;
    foreach (act_q[k]) if (act_q[k] <= line) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_s3 = 0; m_pend = 0; m_mask = 0; m_addr = 0;
    m_gie = 0; m_jump = 0; m_ret = 0; m_raddr = 0; m_phase = 0; m_line = 0;
    act_q.delete(); exp_q.delete();
  endtask

  task automatic model_edge();
    logic [3:0] edg;
    bit nx_enter, nx_ret;
    int sel;
    if (reset) begin
      model_reset();
      return;
    end
    edg = m_s2 & ~m_s3;
    nx_enter = 0; nx_ret = 0; sel = 0;
    if (m_phase == 0) begin
      if (reti && exp_q.size() > 0) nx_ret = 1;
      else if (m_gie && !hold) begin
        for (int i = 0; i < 4; i++)
          if (!nx_enter && m_pend[i] && m_mask[i] && may_enter(i)) begin
            nx_enter = 1; sel = i;
          end
      end
    end else if (m_phase == 1) begin
      m_pend[m_line] = 1'b0;
      act_q.push_back(m_line);
      exp_q.push_back(8'(pc + 8'd1));
    end else begin
      void'(act_q.pop_back());
      void'(exp_q.pop_back());
    end
    m_pend  = m_pend | edg;
    if (mask_we) m_mask = mask_data;
    if (di) m_gie = 0; else if (ei) m_gie = 1;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq;
    m_jump  = nx_enter;
    m_addr  = nx_enter ? 4'(4'hC + sel) : 4'h0;
    m_ret   = nx_ret;
    m_raddr = nx_ret ? exp_q[$] : 8'h00;
    m_line  = nx_enter ? sel : m_line;
    m_phase = nx_ret ? 2 : (nx_enter ? 1 : 0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("jump", {irq_jump, irq_jump_address}, {m_jump, m_addr});
    check("ret", {ret_jump, ret_addr}, {m_ret, m_raddr});
    check("status", {irq_pending, irq_active, irq_depth},
          {m_pend, act_vec(), 3'(exp_q.size())});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    reset = 1; irq = 0; mask_we = 0; mask_data = 0; ei = 0; di = 0;
    reti = 0; hold = 0; pc = 0;
    repeat (2) step();
    reset = 0;
    step();
  endtask

  task automatic setup(input logic [3:0] m);
    mask_we = 1; mask_data = m; ei = 1;
    step();
    mask_we = 0; ei = 0;
    step();
  endtask

  task automatic pulse(input logic [3:0] bits);
    irq = irq | bits;
    repeat (2) step();
    irq = irq & ~bits;
    step();
  endtask

  task automatic wait_jump(input int max, output logic [3:0] a);
    for (int n = 0; n < max && !irq_jump; n++) step();
    if (!irq_jump) check("jump_timeout", 0, 1);
    a = irq_jump_address;
  endtask

  task automatic wait_ret(input int max, output logic [7:0] r);
    for (int n = 0; n < max && !ret_jump; n++) step();
    if (!ret_jump) check("ret_timeout", 0, 1);
    r = ret_addr;
  endtask

  task automatic do_reti();
    reti = 1;
    step();
    reti = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a;
    logic [7:0] r;
    int gap;
    reset = 1; irq = 0; mask_we = 0; mask_data = 0; ei = 0; di = 0;
    reti = 0; hold = 0; pc = 0;
    model_reset();
    #1;
    check("reset_state", {irq_jump, irq_jump_address, ret_jump, ret_addr,
                          irq_pending, irq_active, irq_depth}, 0);
    repeat (3) step();
    reset = 0;
    step();

    // single interrupt
    setup(4'hF);
    pc = 8'h37;
    pulse(4'b0100);
    wait_jump(10, a);
    check("single_addr", a, 4'hE);
    step();
    check("single_active", irq_active, 4'b0100);
    do_reti();
    wait_ret(10, r);
    check("single_ret", r, 8'h38);
    step();
    check("single_active_clear", irq_active, 4'b0000);

    // fixed priority
    do_reset();
    setup(4'hF);
    pulse(4'b1010);
    wait_jump(10, a);
    check("prio_first", a, 4'hD);
    step();
    do_reti();
    wait_ret(10, r);
    wait_jump(10, a);
    check("prio_second", a, 4'hF);
    step();
    do_reti();
    wait_ret(10, r);
    step();

    // mask gating
    do_reset();
    setup(4'b1110);
    pulse(4'b0001);
    repeat (6) step();
    check("mask_pending_kept", irq_pending[0], 1'b1);
    mask_we = 1; mask_data = 4'hF;
    step();
    mask_we = 0;
    wait_jump(10, a);
    check("mask_release", a, 4'hC);
    step();
    do_reti();
    wait_ret(10, r);
    step();

    // hold gating
    hold = 1;
    pulse(4'b0001);
    repeat (6) step();
    check("hold_pending_kept", irq_pending[0], 1'b1);
    hold = 0;
    wait_jump(10, a);
    check("hold_release", a, 4'hC);
    step();
    do_reti();
    wait_ret(10, r);
    step();

    // di gating, then ei releases
    di = 1;
    step();
    di = 0;
    pulse(4'b0001);
    repeat (6) step();
    check("di_pending_kept", irq_pending[0], 1'b1);
    ei = 1;
    step();
    ei = 0;
    wait_jump(10, a);
    check("ei_release", a, 4'hC);
    step();
    do_reti();
    wait_ret(10, r);
    step();

    // return address wraps
    pc = 8'hFF;
    pulse(4'b0100);
    wait_jump(10, a);
    step();
    pc = 8'h50;
    do_reti();
    wait_ret(10, r);
    check("wrap_ret", r, 8'h00);
    step();

    // reti with another request waiting: RETURN first, ENTER two cycles later
    pc = 8'h20;
    pulse(4'b0100);
    wait_jump(10, a);
    step();
    pulse(4'b1000);
    check("blocked_pending", irq_pending[3], 1'b1);
    do_reti();
    check("reti_ret_pulse", ret_jump, 1'b1);
    gap = 0;
    while (!irq_jump && gap < 10) begin step(); gap++; end
    check("reti_enter_gap", gap, 2);
    check("reti_enter_addr", irq_jump_address, 4'hF);
    step();
    do_reti();
    wait_ret(10, r);
    step();

`ifdef IRQ_NESTING_EN
    // nested preemption fills the stack, returns in LIFO order
    do_reset();
    setup(4'hF);
    for (int k = 0; k < 4; k++) begin
      pc = 8'(8'h10 * (k + 1));
      pulse(4'(4'b1000 >> k));
      wait_jump(10, a);
      check("nest_addr", a, 4'(4'hF - k));
      step();
      if (k == 1) check("nest_depth2", irq_depth, 3'd2);
    end
    check("nest_depth4", irq_depth, 3'd4);
    pulse(4'b1000);
    repeat (6) step();
    check("nest_full_pending", irq_pending[3], 1'b1);
    for (int k = 3; k >= 0; k--) begin
      do_reti();
      wait_ret(10, r);
      check("nest_lifo", r, 8'(8'h10 * (k + 1) + 1));
      step();
    end
`endif

    // reset mid-ENTER aborts and clears everything at once
    do_reset();
    setup(4'hF);
    pulse(4'b0001);
    wait_jump(10, a);
    reset = 1;
    #1;
    check("reset_mid_enter", {irq_jump, irq_jump_address, ret_jump, ret_addr,
                              irq_pending, irq_active, irq_depth}, 0);
    step();
    reset = 0;
    step();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
      mask_we   = ($urandom_range(0, 15) == 0);
      mask_data = 4'($urandom_range(0, 15));
      ei        = ($urandom_range(0, 7) == 0);
      di        = ($urandom_range(0, 19) == 0);
      reti      = ($urandom_range(0, 5) == 0);
      hold      = ($urandom_range(0, 3) == 0);
      pc        = 8'($urandom_range(0, 255));
      reset     = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
